// File: rtl/block_dispatcher.sv
// Launch-stage dispatcher: splits a latched kernel thread count into fixed-size
// blocks, hands them to free cores, recycles finished cores and flags kernel done.
module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  localparam int TCW              = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               thread_count,
  input  logic [NUM_CORES-1:0]     core_done,
  output logic [NUM_CORES-1:0]     core_start,
  output logic [NUM_CORES-1:0]     core_reset,
  output logic [NUM_CORES*8-1:0]   core_block_id,
  output logic [NUM_CORES*TCW-1:0] core_thread_count,
  output logic                     done
);

  // state | meaning
  // IDLE  | waiting for start; latches thread count and block total
  // RUN   | retiring finished cores, then handing out blocks in core order
  // DONE  | every block completed; done held until start drops

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int           LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam logic [7:0]   TPB_MASK = 8'(THREADS_PER_BLOCK - 1);
  localparam logic [7:0]   TPB_8    = 8'(THREADS_PER_BLOCK);
  localparam logic [TCW-1:0] TPB_TC = TCW'(THREADS_PER_BLOCK);

  state_t                   state_q, state_d;
  logic [7:0]               tc_q, tc_d;
  logic [7:0]               total_q, total_d;
  logic [7:0]               disp_q, disp_d;
  logic [7:0]               comp_q, comp_d;
  logic [NUM_CORES-1:0]     busy_q, busy_d;
  logic [NUM_CORES-1:0]     cool_q, cool_d;
  logic [NUM_CORES-1:0]     start_q, start_d;
  logic [NUM_CORES-1:0]     crst_q, crst_d;
  logic [NUM_CORES*8-1:0]   id_q, id_d;
  logic [NUM_CORES*TCW-1:0] cnt_q, cnt_d;
  logic                     done_q, done_d;

  logic [7:0] disp_v;
  logic [7:0] comp_v;
  logic [7:0] rem;

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    total_d = total_q;
    disp_d  = disp_q;
    comp_d  = comp_q;
    busy_d  = busy_q;
    cool_d  = '0;
    start_d = start_q;
    crst_d  = '0;
    id_d    = id_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    disp_v  = disp_q;
    comp_v  = comp_q;
    rem     = '0;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          tc_d    = thread_count;
          // ceil without an 8-bit carry out of tc + TPB - 1
          total_d = (thread_count >> LOG2_TPB) + {7'd0, |(thread_count & TPB_MASK)};
          disp_d  = '0;
          comp_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (comp_q == total_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (busy_q[i] && core_done[i]) begin
              start_d[i] = 1'b0;
              crst_d[i]  = 1'b1;
              cool_d[i]  = 1'b1;
              busy_d[i]  = 1'b0;
              comp_v     = comp_v + 8'd1;
            end
          end
          // a core retired this cycle still reads busy, so it waits out its pulse
          for (int i = 0; i < NUM_CORES; i++) begin
            if (!busy_q[i] && !cool_q[i] && !crst_q[i] && (disp_v < total_q)) begin
              rem                  = tc_q - (disp_v << LOG2_TPB);
              id_d[i*8 +: 8]       = disp_v;
              cnt_d[i*TCW +: TCW]  = (rem >= TPB_8) ? TPB_TC : rem[TCW-1:0];
              start_d[i]           = 1'b1;
              busy_d[i]            = 1'b1;
              disp_v               = disp_v + 8'd1;
            end
          end
          disp_d = disp_v;
          comp_d = comp_v;
        end
      end

      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tc_q    <= '0;
      total_q <= '0;
      disp_q  <= '0;
      comp_q  <= '0;
      busy_q  <= '0;
      cool_q  <= '0;
      start_q <= '0;
      crst_q  <= '1;
      id_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      total_q <= total_d;
      disp_q  <= disp_d;
      comp_q  <= comp_d;
      busy_q  <= busy_d;
      cool_q  <= cool_d;
      start_q <= start_d;
      crst_q  <= crst_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign core_start        = start_q;
  assign core_reset        = crst_q;
  assign core_block_id     = id_q;
  assign core_thread_count = cnt_q;
  assign done              = done_q;

endmodule
